// File: rtl/bus_pkg.sv
// Shared definitions for the 16-bit wired-OR memory bus: widths, mode encoding,
// responder FSM state codes and the captured request payload.
package bus_pkg;

  localparam int unsigned BUS_WIDTH = 16;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  typedef struct packed {
    logic                 mode;
    logic [BUS_WIDTH-1:0] locator;
    logic [BUS_WIDTH-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_scratchpad_responder_if.sv
// Shared memory bus bundle: initiator drives the request side, responders
// drive the ORed read_bus/response side.
interface bus_scratchpad_responder_if;
  import bus_pkg::*;

  logic                 request;
  logic                 mode_flag;
  logic [BUS_WIDTH-1:0] locator;
  logic [BUS_WIDTH-1:0] write_bus;
  logic [BUS_WIDTH-1:0] read_bus;
  logic                 response;

  modport master (
    output request, mode_flag, locator, write_bus,
    input  read_bus, response
  );

  modport slave (
    input  request, mode_flag, locator, write_bus,
    output read_bus, response
  );

endinterface

// File: rtl/bus_scratchpad_responder_scratch_ram.sv
// Single-port synchronous RAM with a one-cycle registered read; contents are
// never reset.
module scratch_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_scratchpad_responder.sv
// Address-decoded scratchpad responder on the wired-OR memory bus with
// programmable wait states and a four-phase request/response handshake.
module bus_scratchpad_responder
  import bus_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'h8000,
  parameter int unsigned SIZE_LOG2 = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  bus_scratchpad_responder_if.slave  bus,
  output logic                       busy
);

  localparam int unsigned DEPTH = 1 << SIZE_LOG2;
  localparam int unsigned CNT_W = 4;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIZE_LOG2-1:0] addr_q, addr_d;
  bus_req_t             req_q, req_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [BUS_WIDTH-1:0] read_bus_q, read_bus_d;
  logic                 response_q, response_d;
  logic                 busy_q, busy_d;

  logic                 sel_c;
  logic                 ram_we_c;
  logic [BUS_WIDTH-1:0] ram_rdata;

  assign sel_c = bus.request &&
                 (bus.locator[15:SIZE_LOG2] == BASE[15:SIZE_LOG2]);

  scratch_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BUS_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (addr_q),
    .wdata (req_q.wdata),
    .rdata (ram_rdata)
  );

  // Next-state and output decode; response/read_bus only rise in RESPOND.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    req_d      = req_q;
    data_d     = data_q;
    read_bus_d = '0;
    response_d = 1'b0;
    ram_we_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_c) begin
          addr_d  = bus.locator[SIZE_LOG2-1:0];
          req_d   = '{mode: bus.mode_flag, locator: bus.locator, wdata: bus.write_bus};
          cnt_d   = CNT_W'(LATENCY);
          state_d = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!bus.request) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_we_c = (req_q.mode == MODE_WRITE);
        state_d  = ST_RESPOND;
      end
      default: begin
        if (!bus.request) begin
          state_d = ST_IDLE;
        end else begin
          response_d = 1'b1;
          // RAM read data lands one cycle after ACCESS; hold it thereafter.
          if (!response_q) data_d = ram_rdata;
          if (req_q.mode == MODE_READ)
            read_bus_d = response_q ? data_q : ram_rdata;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      req_q      <= '0;
      data_q     <= '0;
      read_bus_q <= '0;
      response_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      data_q     <= data_d;
      read_bus_q <= read_bus_d;
      response_q <= response_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.read_bus = read_bus_q;
  assign bus.response = response_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_bus_scratchpad_responder.sv
// Bench for bus_scratchpad_responder: two responders share one bus (LATENCY 2
// at 0x8000, LATENCY 0 at 0x4000), driven by a vector table plus corner sequences.
module tb_bus_scratchpad_responder;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        mode;
  logic [15:0] loc;
  logic [15:0] wd;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  bus_scratchpad_responder_if bus_a ();
  bus_scratchpad_responder_if bus_b ();

  assign bus_a.request   = req;
  assign bus_a.mode_flag = mode;
  assign bus_a.locator   = loc;
  assign bus_a.write_bus = wd;
  assign bus_b.request   = req;
  assign bus_b.mode_flag = mode;
  assign bus_b.locator   = loc;
  assign bus_b.write_bus = wd;

  bus_scratchpad_responder #(.BASE(16'h8000), .SIZE_LOG2(8), .LATENCY(2)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .busy  (busy_a)
  );

  bus_scratchpad_responder #(.BASE(16'h4000), .SIZE_LOG2(8), .LATENCY(0)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .busy  (busy_b)
  );

  typedef struct {
    logic        inst;
    logic        mode;
    logic [15:0] loc;
    logic [15:0] wdata;
    logic        served;
    logic [15:0] exp_rd;
    int          lat;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t vecs [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic resp_of(input logic inst);
    return inst ? bus_b.response : bus_a.response;
  endfunction

  function automatic logic [15:0] rd_of(input logic inst);
    return inst ? bus_b.read_bus : bus_a.read_bus;
  endfunction

  function automatic logic busy_of(input logic inst);
    return inst ? busy_b : busy_a;
  endfunction

  // One full four-phase transaction with latency and wired-OR checks.
  task automatic run_txn(input vec_t v, input string tag);
    int   got;
    logic busy_seen;
    logic rd_leak;
    got       = -1;
    busy_seen = 1'b0;
    rd_leak   = 1'b0;
    @(negedge clk);
    req = 1'b1; mode = v.mode; loc = v.loc; wd = v.wdata;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clk); #1;
      busy_seen |= busy_a | busy_b;
      if (e == 0 && v.served) check({tag, " busy_at_E0"}, 16'(busy_of(v.inst)), 16'd1);
      if (bus_a.response || bus_b.response) begin
        got = e;
        break;
      end
      if ((bus_a.read_bus | bus_b.read_bus) !== 16'h0) rd_leak = 1'b1;
    end
    check({tag, " read_bus_zero_before_resp"}, 16'(rd_leak), 16'd0);
    if (!v.served) begin
      check({tag, " unserved_resp"}, 16'(got != -1), 16'd0);
      check({tag, " unserved_busy"}, 16'(busy_seen), 16'd0);
      @(negedge clk); req = 1'b0;
      @(posedge clk); #1;
    end else begin
      check({tag, " latency"}, 16'(got), 16'(v.lat));
      check({tag, " resp_owner"}, 16'(resp_of(v.inst)), 16'd1);
      check({tag, " read_bus"}, rd_of(v.inst), v.mode ? 16'h0 : v.exp_rd);
      @(posedge clk); #1;
      check({tag, " read_bus_hold"}, rd_of(v.inst), v.mode ? 16'h0 : v.exp_rd);
      @(negedge clk); req = 1'b0;
      @(posedge clk); #1;
      check({tag, " resp_release"}, 16'(resp_of(v.inst)), 16'd0);
      check({tag, " read_bus_release"}, rd_of(v.inst), 16'h0);
      @(posedge clk); #1;
      check({tag, " busy_release"}, 16'(busy_of(v.inst)), 16'd0);
    end
  endtask

  task automatic wait_resp_a(input string tag);
    logic seen;
    seen = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (bus_a.response) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " response_seen"}, 16'(seen), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic resp_seen;
    vec_t v;

    vecs[0] = '{1'b0, MODE_WRITE, 16'h8005, 16'hBEEF, 1'b1, 16'h0000, 4};
    vecs[1] = '{1'b0, MODE_READ,  16'h8005, 16'h0000, 1'b1, 16'hBEEF, 4};
    vecs[2] = '{1'b0, MODE_WRITE, 16'h80FF, 16'h1234, 1'b1, 16'h0000, 4};
    vecs[3] = '{1'b0, MODE_READ,  16'h80FF, 16'h0000, 1'b1, 16'h1234, 4};
    vecs[4] = '{1'b0, MODE_READ,  16'h8100, 16'h0000, 1'b0, 16'h0000, 0};
    vecs[5] = '{1'b0, MODE_WRITE, 16'h7FFF, 16'hDEAD, 1'b0, 16'h0000, 0};
    vecs[6] = '{1'b0, MODE_WRITE, 16'h8010, 16'h5555, 1'b1, 16'h0000, 4};
    vecs[7] = '{1'b0, MODE_WRITE, 16'h8021, 16'h2222, 1'b1, 16'h0000, 4};
    vecs[8] = '{1'b1, MODE_WRITE, 16'h4000, 16'h0001, 1'b1, 16'h0000, 2};
    vecs[9] = '{1'b1, MODE_READ,  16'h4000, 16'h0000, 1'b1, 16'h0001, 2};

    reset = 1'b1; req = 1'b0; mode = 1'b0; loc = 16'h0; wd = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset response_a", 16'(bus_a.response), 16'd0);
    check("reset read_bus_a", bus_a.read_bus, 16'h0);
    check("reset busy_a", 16'(busy_a), 16'd0);
    check("reset busy_b", 16'(busy_b), 16'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Abort: request withdrawn while still waiting.
    @(negedge clk);
    req = 1'b1; mode = MODE_WRITE; loc = 16'h8010; wd = 16'hAAAA;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    resp_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      resp_seen |= bus_a.response;
    end
    check("abort response", 16'(resp_seen), 16'd0);
    check("abort busy", 16'(busy_a), 16'd0);
    v = '{1'b0, MODE_READ, 16'h8010, 16'h0000, 1'b1, 16'h5555, 4};
    run_txn(v, "abort_readback");

    // Reset while a read is responding.
    @(negedge clk);
    req = 1'b1; mode = MODE_READ; loc = 16'h8005;
    wait_resp_a("rst_mid");
    check("rst_mid read_bus_before", bus_a.read_bus, 16'hBEEF);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid response", 16'(bus_a.response), 16'd0);
    check("rst_mid read_bus", bus_a.read_bus, 16'h0);
    check("rst_mid busy", 16'(busy_a), 16'd0);
    @(negedge clk); reset = 1'b0; req = 1'b0;
    v = '{1'b0, MODE_READ, 16'h8005, 16'h0000, 1'b1, 16'hBEEF, 4};
    run_txn(v, "rst_fresh_read");

    // Operands changed after capture must be ignored.
    @(negedge clk);
    req = 1'b1; mode = MODE_WRITE; loc = 16'h8020; wd = 16'h0F0F;
    @(posedge clk);
    @(negedge clk); loc = 16'h8021; wd = 16'hFFFF;
    wait_resp_a("stab");
    @(negedge clk); req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    v = '{1'b0, MODE_READ, 16'h8020, 16'h0000, 1'b1, 16'h0F0F, 4};
    run_txn(v, "stab_captured_addr");
    v = '{1'b0, MODE_READ, 16'h8021, 16'h0000, 1'b1, 16'h2222, 4};
    run_txn(v, "stab_other_addr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_scratchpad_responder.md
Name: bus_scratchpad_responder

Overview:
- Responder (target) on the shared 16-bit memory bus: request / mode_flag / locator / write_bus in, read_bus / response out.
- Provides a small address-decoded scratchpad RAM window with programmable wait states, so it coexists with the main memory on the wired-OR bus.
- Serves loader, CPU and reader initiators alike. Drives all-zero outputs whenever it is not answering, so its outputs can be ORed into the bus.

Parameters:
- BASE, 16'h8000, window base address; must be aligned to 2^SIZE_LOG2.
- SIZE_LOG2, 8, log2 of window depth in 16-bit words (legal range 1..15).
- LATENCY, 2, wait-state cycles between request capture and array access (legal range 0..15).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- request  in  1  bus request from the ORed initiators.
- mode_flag  in  1  1 = write, 0 = read; qualified by request.
- locator  in  16  word address.
- write_bus  in  16  write data; valid while request is high and mode_flag is 1.
- read_bus  out  16  read data; nonzero only in RESPOND of a read.
- response  out  1  handshake acknowledge; registered.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Select rule: sel = request & (locator[15:SIZE_LOG2] == BASE[15:SIZE_LOG2]). When sel is 0 the block ignores the bus.
- Handshake is four-phase:
  - Initiator raises request and holds it.
  - Block raises response.
  - Initiator drops request.
  - Block drops response on the next edge.
  - Initiator must see response low before re-requesting.
- FSM states: IDLE, WAIT, ACCESS, RESPOND.
- IDLE:
  - On sel, latch addr = locator[SIZE_LOG2-1:0], mode_flag and write_bus.
  - Load cnt = LATENCY.
  - Next state is WAIT, or ACCESS if LATENCY == 0.
- WAIT:
  - If request drops, abort: return to IDLE with no side effect.
  - Otherwise decrement cnt; go to ACCESS when cnt reaches 1, or immediately if cnt was 1.
- ACCESS:
  - Write: mem[addr] <= latched data.
  - Read: data_q <= mem[addr].
  - Next state is RESPOND unconditionally. A request dropped during ACCESS still completes the access.
- RESPOND:
  - response = 1; read_bus = data_q for a read, 16'h0 for a write.
  - When request is sampled low, go to IDLE; response and read_bus return to 0 on that same edge.
- Latency: with request sampled at edge E0, response is first high after edge E(LATENCY+2). For LATENCY=0, response is high after E2.
- Latched operands: changes to locator, mode_flag or write_bus after the capture edge are ignored.
- Address wrap: addr is a SIZE_LOG2-bit field. BASE+2^SIZE_LOG2-1 is the last selected word; BASE+2^SIZE_LOG2 is unselected.
- Reset (any state, including mid-transaction):
  - State goes to IDLE; response, read_bus, busy, cnt and data_q go to 0.
  - An uncommitted write is discarded.
  - RAM contents are not reset, and the bench must write before reading.
- Simultaneous reset and request: reset wins, and the request is not captured that edge.
- Wired-OR rule: read_bus and response are exactly 0 in IDLE, WAIT and ACCESS.

Decomposition:
- Shared package (bus_pkg), also to be used by memory, peripheral and initiator code:
  - MODE_READ = 1'b0, MODE_WRITE = 1'b1.
  - BUS_WIDTH = 16.
  - A state enum or localparams for IDLE, WAIT, ACCESS and RESPOND.
- One sub-module, scratch_ram:
  - Single-port synchronous RAM, parameterised by depth and width.
  - Ports: clk, we, addr, wdata, rdata.
  - One-cycle registered read, no reset.
- The FSM, decode and counter live in the top.

Test Plan:
- Write then read, LATENCY=2:
  - Write 16'hBEEF to 16'h8005; response first high after E4; read_bus stays 0 throughout.
  - Drop request, then read 16'h8005 → read_bus = 16'hBEEF exactly while response is high, and 0 after the release edge.
- Decode boundaries:
  - Request at 16'h80FF is served (write 16'h1234, read back 16'h1234).
  - Request at 16'h8100 or 16'h7FFF → response stays 0 for 20 cycles and busy stays 0.
- Abort:
  - Write 16'hAAAA to 16'h8010, then drop request after E1 (during WAIT) → no response; busy back to 0.
  - A later read of 16'h8010 returns the previously written 16'h5555.
- Reset mid-transaction:
  - Assert reset during RESPOND of a read → next edge response = 0, read_bus = 0, busy = 0.
  - A fresh read then completes normally.
- Back-to-back at LATENCY=0:
  - Write 16'h0001 to 16'h8000, then read it back immediately after response falls.
  - response is first high after E2 each time; the read returns 16'h0001.
- Operand stability: change locator and write_bus during WAIT → the stored value and address are those captured at E0.
